// File: rtl/uart_pin_pkg.sv
// Shared command/state types, error bit positions and frame helpers for uart_pin_ctrl.
// Parity support is selected per build by UART_PIN_PARITY_EN in uart_pin_ctrl.
package uart_pin_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WRITE    = 3'd1,
        CMD_READ     = 3'd2,
        CMD_CLEAR    = 3'd3,
        CMD_SET_RATE = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam int ERR_RD_UNDERRUN = 0;
    localparam int ERR_TX_OVERFLOW = 1;
    localparam int ERR_RX_OVERRUN  = 2;
    localparam int ERR_FRAMING     = 3;
    localparam int ERR_PARITY      = 4;

    function automatic int frameLen(input int dataW, input bit parityEn);
        return dataW + 2 + (parityEn ? 1 : 0);
    endfunction

    // Codes 5..7 are reserved and behave exactly like NOP.
    function automatic logic isNop(input logic [2:0] c);
        return (c == 3'(CMD_NOP)) || (c > 3'(CMD_SET_RATE));
    endfunction

endpackage

// File: rtl/uart_pin_fifo.sv
// Synchronous show-ahead FIFO; push and pop take effect on the clock edge, head visible combinationally.
// Push to a full FIFO is dropped unless a pop lands in the same cycle; pop on empty is ignored.
module uart_pin_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic                       clear,
    input  logic                       wrEn,
    input  logic [WIDTH-1:0]           wrData,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic             doWr, doRd;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign doRd   = rdEn && !empty;
    assign doWr   = wrEn && (!full || doRd);
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doWr && nReset && !clear) mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk) begin
        if (!nReset || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + AW'(1);
            if (doRd) rdPtr <= rdPtr + AW'(1);
            case ({doWr, doRd})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_pin_ctrl.sv
// Pin-commanded UART: edge-triggered host commands, TX/RX FIFOs, per-engine baud divisor, CTS/RTS.
// Optional even parity via UART_PIN_PARITY_EN; tx starts 3 cycles after a WRITE is sampled, cts gates frame starts only.
module uart_pin_ctrl
    import uart_pin_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV0       = 5207,
    parameter int DIV1       = 2603,
    parameter int DIV2       = 867,
    parameter int DIV3       = 433
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [2:0]        cmd,
    input  logic [1:0]        rate_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              tx_full,
    output logic              rx_empty,
    input  logic              rx,
    output logic              tx,
    input  logic              cts,
    output logic              rts,
    output logic              err,
    output logic [4:0]        err_code
);

`ifdef UART_PIN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int NBITS = frameLen(DATA_W, PAR_EN) - 2;
    localparam int BW    = $clog2(DATA_W + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [CW-1:0] RTS_MAX  = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0] D0 = 16'(DIV0), D1 = 16'(DIV1), D2 = 16'(DIV2), D3 = 16'(DIV3);

    logic [2:0]        cmdReg, cmdPrev;
    logic              execEn, doWrite, doRead, doClear, doSetRate;
    logic              ctsS1, ctsS2, rxS1, rxS2, rxS3, rxFall;
    logic [15:0]       pendDiv, rateDiv;
    logic [4:0]        errCode, errEvents;

    logic [DATA_W-1:0] txHead, rxHead;
    logic [NBITS-1:0]  txLoad;
    logic              txFull, txEmpty, rxFull, rxEmpty, txPop, rxPush, rxPopOk;
    logic [CW-1:0]     txCount, rxCount;

    tx_state_e         txState, txStateNext;
    logic [15:0]       txCnt, txCntNext, txDiv, txDivNext;
    logic [BW-1:0]     txBit, txBitNext;
    logic [NBITS-1:0]  txShift, txShiftNext;
    logic              txBitEnd;

    rx_state_e         rxState, rxStateNext;
    logic [15:0]       rxCnt, rxCntNext, rxDiv, rxDivNext;
    logic [BW-1:0]     rxBit, rxBitNext;
    logic [NBITS-1:0]  rxShift, rxShiftNext;
    logic              rxBitEnd, rxDone, rxParBad;

    // Commands fire only on a registered NOP -> non-NOP transition.
    assign execEn    = isNop(cmdPrev) && !isNop(cmdReg);
    assign doWrite   = execEn && (cmdReg == 3'(CMD_WRITE));
    assign doRead    = execEn && (cmdReg == 3'(CMD_READ));
    assign doClear   = execEn && (cmdReg == 3'(CMD_CLEAR));
    assign doSetRate = execEn && (cmdReg == 3'(CMD_SET_RATE));
    assign rxFall    = rxS3 && !rxS2;
    assign rxPopOk   = doRead && !rxEmpty;

    always_comb begin
        rateDiv = D0;
        case (rate_sel)
            2'd0:    rateDiv = D0;
            2'd1:    rateDiv = D1;
            2'd2:    rateDiv = D2;
            default: rateDiv = D3;
        endcase
    end

`ifdef UART_PIN_PARITY_EN
    assign txLoad   = {^txHead, txHead};
    assign rxParBad = ^rxShift;
`else
    assign txLoad   = txHead;
    assign rxParBad = 1'b0;
`endif

    uart_pin_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) uTxFifo (
        .clk(clk), .nReset(nReset), .clear(doClear), .wrEn(doWrite), .wrData(wr_data),
        .rdEn(txPop), .rdData(txHead), .full(txFull), .empty(txEmpty), .count(txCount)
    );

    uart_pin_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) uRxFifo (
        .clk(clk), .nReset(nReset), .clear(doClear), .wrEn(rxPush), .wrData(rxShift[DATA_W-1:0]),
        .rdEn(doRead), .rdData(rxHead), .full(rxFull), .empty(rxEmpty), .count(rxCount)
    );

    assign tx_full  = txFull;
    assign rx_empty = rxEmpty;
    assign rts      = (rxCount <= RTS_MAX);
    assign err_code = errCode;
    assign err      = |errCode;

    assign txBitEnd = (txCnt == txDiv - 16'd1);
    assign rxBitEnd = (rxCnt == rxDiv - 16'd1);

    always_comb begin
        txStateNext = txState;
        txCntNext   = txCnt + 16'd1;
        txBitNext   = txBit;
        txShiftNext = txShift;
        txDivNext   = txDiv;
        txPop       = 1'b0;
        case (txState)
            TX_IDLE: begin
                txCntNext = '0;
                if (!txEmpty && ctsS2 && !doClear) begin
                    txPop       = 1'b1;
                    txStateNext = TX_START;
                    txDivNext   = pendDiv;
                    txShiftNext = txLoad;
                end
            end
            TX_START: if (txBitEnd) begin
                txCntNext   = '0;
                txBitNext   = '0;
                txStateNext = TX_DATA;
            end
            TX_DATA: if (txBitEnd) begin
                txCntNext   = '0;
                txShiftNext = txShift >> 1;
                if (txBit == LAST_BIT) txStateNext = TX_STOP;
                else                   txBitNext   = txBit + BW'(1);
            end
            TX_STOP: if (txBitEnd) begin
                txCntNext   = '0;
                txStateNext = TX_IDLE;
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    // START re-samples at half a bit, so every later sample lands mid-bit.
    always_comb begin
        rxStateNext = rxState;
        rxCntNext   = rxCnt + 16'd1;
        rxBitNext   = rxBit;
        rxShiftNext = rxShift;
        rxDivNext   = rxDiv;
        rxDone      = 1'b0;
        case (rxState)
            RX_IDLE: begin
                rxCntNext = '0;
                if (rxFall) begin
                    rxStateNext = RX_START;
                    rxDivNext   = pendDiv;
                end
            end
            RX_START: if (rxCnt == (rxDiv >> 1) - 16'd1) begin
                rxCntNext   = '0;
                rxBitNext   = '0;
                rxStateNext = rxS2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rxBitEnd) begin
                rxCntNext   = '0;
                rxShiftNext = {rxS2, rxShift[NBITS-1:1]};
                if (rxBit == LAST_BIT) rxStateNext = RX_STOP;
                else                   rxBitNext   = rxBit + BW'(1);
            end
            RX_STOP: if (rxBitEnd) begin
                rxCntNext   = '0;
                rxStateNext = RX_IDLE;
                rxDone      = 1'b1;
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    assign rxPush = rxDone && rxS2 && !rxParBad;

    always_comb begin
        errEvents                  = '0;
        errEvents[ERR_RD_UNDERRUN] = doRead && rxEmpty;
        errEvents[ERR_TX_OVERFLOW] = doWrite && (txCount == CNT_FULL) && !txPop;
        errEvents[ERR_RX_OVERRUN]  = rxPush && rxFull && !doRead;
        errEvents[ERR_FRAMING]     = rxDone && !rxS2;
        errEvents[ERR_PARITY]      = rxDone && rxParBad;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            cmdReg   <= '0;
            cmdPrev  <= '0;
            {ctsS1, ctsS2, rxS1, rxS2, rxS3} <= '1;
            pendDiv  <= D0;
            txState  <= TX_IDLE;
            txCnt    <= '0;
            txBit    <= '0;
            txShift  <= '0;
            txDiv    <= D0;
            tx       <= 1'b1;
            rxState  <= RX_IDLE;
            rxCnt    <= '0;
            rxBit    <= '0;
            rxShift  <= '0;
            rxDiv    <= D0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            errCode  <= '0;
        end else begin
            cmdReg   <= cmd;
            cmdPrev  <= cmdReg;
            ctsS1    <= cts;
            ctsS2    <= ctsS1;
            rxS1     <= rx;
            rxS2     <= rxS1;
            rxS3     <= rxS2;
            if (doSetRate) pendDiv <= rateDiv;
            txState  <= txStateNext;
            txCnt    <= txCntNext;
            txBit    <= txBitNext;
            txShift  <= txShiftNext;
            txDiv    <= txDivNext;
            case (txState)
                TX_START: tx <= 1'b0;
                TX_DATA:  tx <= txShift[0];
                default:  tx <= 1'b1;
            endcase
            rxState  <= rxStateNext;
            rxCnt    <= rxCntNext;
            rxBit    <= rxBitNext;
            rxShift  <= rxShiftNext;
            rxDiv    <= rxDivNext;
            rd_valid <= rxPopOk;
            if (rxPopOk) rd_data <= rxHead;
            // An error raised in the same cycle as CLEAR survives it.
            errCode  <= (doClear ? 5'b0 : errCode) | errEvents;
        end
    end

endmodule

// File: tb/tb_uart_pin_ctrl.sv
// Directed bench for uart_pin_ctrl with DIV0=16, DIV1=8, DATA_W=8, FIFO_DEPTH=8, parity disabled.
module tb_uart_pin_ctrl;
    import uart_pin_pkg::*;

    logic       clk = 1'b0;
    logic       nReset;
    logic [2:0] cmd;
    logic [1:0] rate_sel;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, tx_full, rx_empty, rx, tx, cts, rts, err;
    logic [4:0] err_code;
    int         testsRun = 0, testsFailed = 0;

    always #5 clk = ~clk;

    uart_pin_ctrl #(
        .DATA_W(8), .FIFO_DEPTH(8), .DIV0(16), .DIV1(8), .DIV2(4), .DIV3(32)
    ) dut (
        .clk(clk), .nReset(nReset), .cmd(cmd), .rate_sel(rate_sel), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .tx_full(tx_full), .rx_empty(rx_empty),
        .rx(rx), .tx(tx), .cts(cts), .rts(rts), .err(err), .err_code(err_code)
    );

    task automatic doCmd(input logic [2:0] c, input logic [7:0] d);
        cmd = c; wr_data = d;
        @(negedge clk);
        cmd = 3'(CMD_NOP);
        @(negedge clk);
    endtask

    task automatic sendRx(input logic [7:0] d, input logic stopBit, input int bitLen);
        rx = 1'b0;
        repeat (bitLen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bitLen) @(negedge clk);
        end
        rx = stopBit;
        repeat (bitLen) @(negedge clk);
        rx = 1'b1;
        repeat (bitLen) @(negedge clk);
    endtask

    task automatic captureTx(input int bitLen, input int timeout, output logic [7:0] data,
                             output logic stopBit, output int waited, output bit timedOut);
        waited = 0; timedOut = 1'b0; data = '0; stopBit = 1'b0;
        while (tx !== 1'b0 && waited < timeout) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            timedOut = 1'b1;
            return;
        end
        repeat (bitLen / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (bitLen) @(negedge clk);
            data[i] = tx;
        end
        repeat (bitLen) @(negedge clk);
        stopBit = tx;
    endtask

    task automatic test_reset();
        nReset = 1'b0; cmd = 3'(CMD_NOP); rate_sel = 2'd0; wr_data = '0; rx = 1'b1; cts = 1'b1;
        repeat (3) @(negedge clk);
        testsRun++; if (tx !== 1'b1) begin testsFailed++; $display("FAIL reset_tx: got %b want 1", tx); end
        testsRun++; if (rd_data !== 8'h00) begin testsFailed++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        testsRun++; if (err !== 1'b0 || err_code !== 5'b0) begin testsFailed++; $display("FAIL reset_err: got %b/%b want 0/00000", err, err_code); end
        testsRun++; if (rts !== 1'b1) begin testsFailed++; $display("FAIL reset_rts: got %b want 1", rts); end
        testsRun++; if (tx_full !== 1'b0 || rx_empty !== 1'b1) begin testsFailed++; $display("FAIL reset_flags: got full=%b empty=%b want 0/1", tx_full, rx_empty); end
        nReset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        bit         sawFull;
        frame = {1'b1, 8'hA5, 1'b0};
        sawFull = 1'b0;
        cmd = 3'(CMD_WRITE); wr_data = 8'hA5;
        @(negedge clk); cmd = 3'(CMD_NOP);
        repeat (2) @(negedge clk);
        testsRun++; if (tx !== 1'b1) begin testsFailed++; $display("FAIL tx_before_start: got %b want 1", tx); end
        @(negedge clk);
        testsRun++; if (tx !== 1'b0) begin testsFailed++; $display("FAIL tx_start_latency: got %b want 0", tx); end
        for (int c = 1; c < 160; c++) begin
            @(negedge clk);
            if (tx_full) sawFull = 1'b1;
            if (c % 16 == 8) begin
                testsRun++;
                if (tx !== frame[c / 16]) begin testsFailed++; $display("FAIL tx_bit%0d: got %b want %b", c / 16, tx, frame[c / 16]); end
            end
        end
        testsRun++; if (sawFull !== 1'b0) begin testsFailed++; $display("FAIL tx_full_seen: got %b want 0", sawFull); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_read();
        int         pulses;
        logic [7:0] got;
        pulses = 0; got = '0;
        sendRx(8'h3C, 1'b1, 16);
        testsRun++; if (rx_empty !== 1'b0) begin testsFailed++; $display("FAIL rx_stored: got empty=%b want 0", rx_empty); end
        cmd = 3'(CMD_READ);
        @(negedge clk); cmd = 3'(CMD_NOP);
        for (int i = 0; i < 8; i++) begin
            if (rd_valid) begin pulses++; got = rd_data; end
            @(negedge clk);
        end
        testsRun++; if (pulses !== 1) begin testsFailed++; $display("FAIL rx_read_pulses: got %0d want 1", pulses); end
        testsRun++; if (got !== 8'h3C) begin testsFailed++; $display("FAIL rx_read_data: got %h want 3c", got); end
        testsRun++; if (rx_empty !== 1'b1) begin testsFailed++; $display("FAIL rx_read_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] b;
        int         pulses;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            b = 8'h10 + 8'(i);
            sendRx(b, 1'b1, 16);
            if (i == 5) begin
                testsRun++; if (rts !== 1'b1) begin testsFailed++; $display("FAIL rts_after6: got %b want 1", rts); end
            end
            if (i == 6) begin
                testsRun++; if (rts !== 1'b0) begin testsFailed++; $display("FAIL rts_after7: got %b want 0", rts); end
            end
            if (i == 7) begin
                testsRun++; if (err_code !== 5'b0) begin testsFailed++; $display("FAIL no_err_at_full: got %b want 00000", err_code); end
            end
        end
        testsRun++; if (err_code !== 5'b00100) begin testsFailed++; $display("FAIL overrun_code: got %b want 00100", err_code); end
        testsRun++; if (err !== 1'b1) begin testsFailed++; $display("FAIL overrun_err: got %b want 1", err); end
        cmd = 3'(CMD_READ);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 9) cmd = 3'(CMD_NOP);
            if (rd_valid) pulses++;
        end
        testsRun++; if (pulses !== 1) begin testsFailed++; $display("FAIL held_read_pulses: got %0d want 1", pulses); end
        testsRun++; if (rd_data !== 8'h10) begin testsFailed++; $display("FAIL held_read_data: got %h want 10", rd_data); end
        doCmd(3'(CMD_CLEAR), 8'h00);
        testsRun++; if (err !== 1'b0 || err_code !== 5'b0) begin testsFailed++; $display("FAIL clear_err: got %b/%b want 0/00000", err, err_code); end
        testsRun++; if (rx_empty !== 1'b1 || rts !== 1'b1) begin testsFailed++; $display("FAIL clear_fifo: got empty=%b rts=%b want 1/1", rx_empty, rts); end
    endtask

    task automatic test_read_underrun();
        int pulses;
        pulses = 0;
        cmd = 3'(CMD_READ);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 9) cmd = 3'(CMD_NOP);
            if (rd_valid) pulses++;
        end
        testsRun++; if (pulses !== 0) begin testsFailed++; $display("FAIL underrun_pulses: got %0d want 0", pulses); end
        testsRun++; if (rd_data !== 8'h10) begin testsFailed++; $display("FAIL underrun_data_held: got %h want 10", rd_data); end
        testsRun++; if (err_code !== 5'b00001) begin testsFailed++; $display("FAIL underrun_code: got %b want 00001", err_code); end
        cmd = 3'(CMD_READ);
        repeat (3) @(negedge clk);
        cmd = 3'(CMD_CLEAR);
        repeat (3) @(negedge clk);
        cmd = 3'(CMD_NOP);
        repeat (2) @(negedge clk);
        testsRun++; if (err_code !== 5'b00001) begin testsFailed++; $display("FAIL direct_change_ignored: got %b want 00001", err_code); end
        doCmd(3'(CMD_CLEAR), 8'h00);
        testsRun++; if (err_code !== 5'b0) begin testsFailed++; $display("FAIL clear_after_nop: got %b want 00000", err_code); end
    endtask

    task automatic test_cts_flow();
        logic [7:0] d;
        logic       s;
        int         w, lows;
        bit         to;
        lows = 0;
        cts = 1'b0;
        repeat (3) @(negedge clk);
        doCmd(3'(CMD_WRITE), 8'h11);
        doCmd(3'(CMD_WRITE), 8'h22);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        testsRun++; if (lows !== 0) begin testsFailed++; $display("FAIL cts_blocks_start: got %0d low cycles want 0", lows); end
        cts = 1'b1;
        fork
            captureTx(16, 20, d, s, w, to);
            begin repeat (60) @(negedge clk); cts = 1'b0; end
        join
        testsRun++; if (to !== 1'b0 || d !== 8'h11 || s !== 1'b1) begin testsFailed++; $display("FAIL cts_frame1: got to=%b d=%h stop=%b want 0/11/1", to, d, s); end
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        testsRun++; if (lows !== 0) begin testsFailed++; $display("FAIL cts_frame2_waits: got %0d low cycles want 0", lows); end
        cts = 1'b1;
        captureTx(16, 20, d, s, w, to);
        testsRun++; if (to !== 1'b0 || d !== 8'h22 || s !== 1'b1) begin testsFailed++; $display("FAIL cts_frame2: got to=%b d=%h stop=%b want 0/22/1", to, d, s); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       s;
        int         w;
        bit         to;
        doCmd(3'(CMD_WRITE), 8'h96);
        doCmd(3'(CMD_WRITE), 8'h69);
        captureTx(16, 20, d, s, w, to);
        testsRun++; if (to !== 1'b0 || d !== 8'h96) begin testsFailed++; $display("FAIL b2b_frame1: got to=%b d=%h want 0/96", to, d); end
        captureTx(16, 12, d, s, w, to);
        testsRun++; if (to !== 1'b0 || d !== 8'h69 || s !== 1'b1) begin testsFailed++; $display("FAIL b2b_frame2: got to=%b d=%h stop=%b want 0/69/1", to, d, s); end
        testsRun++; if (w > 10) begin testsFailed++; $display("FAIL b2b_gap: got %0d cycles want <=10", w); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_set_rate();
        logic [7:0] d;
        logic       s;
        int         w;
        bit         to;
        doCmd(3'(CMD_WRITE), 8'h5A);
        fork
            captureTx(16, 20, d, s, w, to);
            begin
                repeat (30) @(negedge clk);
                rate_sel = 2'd1;
                doCmd(3'(CMD_SET_RATE), 8'h00);
                doCmd(3'(CMD_WRITE), 8'hC3);
            end
        join
        testsRun++; if (to !== 1'b0 || d !== 8'h5A || s !== 1'b1) begin testsFailed++; $display("FAIL rate_frame_keeps_div: got to=%b d=%h stop=%b want 0/5a/1", to, d, s); end
        captureTx(8, 40, d, s, w, to);
        testsRun++; if (to !== 1'b0 || d !== 8'hC3 || s !== 1'b1) begin testsFailed++; $display("FAIL rate_next_frame: got to=%b d=%h stop=%b want 0/c3/1", to, d, s); end
        repeat (10) @(negedge clk);
        doCmd(3'(CMD_CLEAR), 8'h00);
        sendRx(8'hA5, 1'b0, 8);
        testsRun++; if (err_code !== 5'b01000) begin testsFailed++; $display("FAIL framing_code: got %b want 01000", err_code); end
        testsRun++; if (rx_empty !== 1'b1) begin testsFailed++; $display("FAIL framing_no_push: got empty=%b want 1", rx_empty); end
    endtask

    task automatic test_reset_midframe();
        int  w;
        doCmd(3'(CMD_WRITE), 8'h00);
        w = 0;
        while (tx !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        testsRun++; if (tx !== 1'b0) begin testsFailed++; $display("FAIL midframe_start: got %b want 0", tx); end
        repeat (20) @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        testsRun++; if (tx !== 1'b1) begin testsFailed++; $display("FAIL midframe_reset_tx: got %b want 1", tx); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("FAIL midframe_reset_err: got %b want 0", err); end
        nReset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_rx_read();
        test_rx_overrun();
        test_read_underrun();
        test_cts_flow();
        test_back_to_back();
        test_set_rate();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
